// File: rtl/clktick_pkg.sv
// Shared types and helpers for the clktick_multi tick generator.
// Optional one-shot support is enabled by defining CLKTICK_ONESHOT_EN.
package clktick_pkg;

  localparam int N_BIT_DEF = 16;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_t;

  // Low bit index of channel ch's divisor inside the flattened div bus.
  function automatic int div_lo(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/clktick_chan.sv
// One clock-enable channel: down-counter reloaded from div, registered tick.
// With CLKTICK_ONESHOT_EN defined, a channel can stop in DONE after one tick.
module clktick_chan
  import clktick_pkg::*;
#(
  parameter int N_BIT = N_BIT_DEF
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             restart,
  input  logic [N_BIT-1:0] div,
  output logic             tick
`ifdef CLKTICK_ONESHOT_EN
  ,
  input  logic             oneshot,
  output logic             busy
`endif
);

  state_t           state;
  state_t           state_nxt;
  logic             run;
  logic [N_BIT-1:0] count;

  always_ff @(posedge clkin) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (restart) begin
      state_nxt = RUN;
`ifdef CLKTICK_ONESHOT_EN
    end else if (enable && (state == RUN) && (count == '0) && oneshot) begin
      state_nxt = DONE;
`endif
    end
  end

  always_comb begin
    run = (state == RUN);
  end

`ifdef CLKTICK_ONESHOT_EN
  assign busy = run;
`endif

  // div is only sampled on restart or reload, so mid-period changes wait a period
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (restart) begin
      count <= div;
      tick  <= 1'b0;
    end else if (enable && run) begin
      if (count == '0) begin
        count <= div;
        tick  <= 1'b1;
      end else begin
        count <= count - 1'b1;
        tick  <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/clktick_multi.sv
// N_CH independent clock-enable tick generators plus an aggregate tick.
// Define CLKTICK_ONESHOT_EN to add the oneshot/busy ports.
module clktick_multi
  import clktick_pkg::*;
#(
  parameter int N_BIT = N_BIT_DEF,
  parameter int N_CH  = 4
) (
  input  logic                  clkin,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       enable,
  input  logic [N_CH-1:0]       restart,
  input  logic [N_CH*N_BIT-1:0] div,
`ifdef CLKTICK_ONESHOT_EN
  input  logic [N_CH-1:0]       oneshot,
  output logic [N_CH-1:0]       busy,
`endif
  output logic [N_CH-1:0]       tick,
  output logic                  any_tick
);

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    clktick_chan #(
      .N_BIT(N_BIT)
    ) u_chan (
      .clkin  (clkin),
      .rst_n  (rst_n),
      .enable (enable[i]),
      .restart(restart[i]),
      .div    (div[div_lo(i, N_BIT) +: N_BIT]),
      .tick   (tick[i])
`ifdef CLKTICK_ONESHOT_EN
      ,
      .oneshot(oneshot[i]),
      .busy   (busy[i])
`endif
    );
  end

  // Straight OR of the tick registers: same cycle as tick, no extra latency.
  assign any_tick = |tick;

endmodule

// File: tb/tb_clktick_multi.sv
// Self-checking bench for clktick_multi: directed scenarios plus random stimulus
// against a period-based reference model. Honours CLKTICK_ONESHOT_EN.
module tb_clktick_multi;

  localparam int N_BIT = 4;
  localparam int N_CH  = 4;

  logic                  clkin = 1'b0;
  logic                  rst_n;
  logic [N_CH-1:0]       enable;
  logic [N_CH-1:0]       restart;
  logic [N_CH*N_BIT-1:0] div;
  logic [N_CH-1:0]       tick;
  logic                  any_tick;
`ifdef CLKTICK_ONESHOT_EN
  logic [N_CH-1:0]       oneshot;
  logic [N_CH-1:0]       busy;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: edges left before the next tick, and whether the channel has stopped.
  int remaining [N_CH];
  bit exp_tick  [N_CH];
  bit stopped   [N_CH];
  int tick_cnt  [N_CH];

  always #5 clkin = ~clkin;

  clktick_multi #(
    .N_BIT(N_BIT),
    .N_CH (N_CH)
  ) dut (
    .clkin   (clkin),
    .rst_n   (rst_n),
    .enable  (enable),
    .restart (restart),
    .div     (div),
`ifdef CLKTICK_ONESHOT_EN
    .oneshot (oneshot),
    .busy    (busy),
`endif
    .tick    (tick),
    .any_tick(any_tick)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_div(input int ch, input int val);
    div[ch*N_BIT +: N_BIT] = val[N_BIT-1:0];
  endtask

  // Advance the model by one edge using the inputs presented at that edge.
  task automatic model_edge();
    for (int c = 0; c < N_CH; c++) begin
      int d;
      bit os;
      d  = int'(div[c*N_BIT +: N_BIT]);
      os = 1'b0;
`ifdef CLKTICK_ONESHOT_EN
      os = oneshot[c];
`endif
      if (!rst_n) begin
        remaining[c] = 0;
        exp_tick[c]  = 1'b0;
        stopped[c]   = 1'b0;
      end else if (restart[c]) begin
        remaining[c] = d;
        exp_tick[c]  = 1'b0;
        stopped[c]   = 1'b0;
      end else if (enable[c] && !stopped[c]) begin
        if (remaining[c] == 0) begin
          exp_tick[c]  = 1'b1;
          remaining[c] = d;
          if (os) stopped[c] = 1'b1;
        end else begin
          exp_tick[c]  = 1'b0;
          remaining[c] = remaining[c] - 1;
        end
      end else begin
        exp_tick[c] = 1'b0;
      end
    end
  endtask

  task automatic step(input string tag);
    logic [N_CH-1:0] et;
    logic [N_CH-1:0] eb;
    @(posedge clkin);
    #1;
    model_edge();
    for (int c = 0; c < N_CH; c++) begin
      et[c] = exp_tick[c];
      eb[c] = !stopped[c];
      tick_cnt[c] += int'(tick[c]);
    end
    check_eq({tag, "_tick"}, 64'(tick), 64'(et));
    check_eq({tag, "_any"}, 64'(any_tick), 64'(|et));
`ifdef CLKTICK_ONESHOT_EN
    check_eq({tag, "_busy"}, 64'(busy), 64'(eb));
`endif
  endtask

  task automatic clear_counts();
    for (int c = 0; c < N_CH; c++) tick_cnt[c] = 0;
  endtask

  initial begin
    rst_n   = 1'b0;
    enable  = '1;
    restart = '0;
    div     = '0;
`ifdef CLKTICK_ONESHOT_EN
    oneshot = '0;
`endif
    set_div(0, 0);
    set_div(1, 1);
    set_div(2, 4);
    set_div(3, 9);

    // Reset state, then all four channels free-running from the first enabled edge.
    step("reset");
    step("reset");
    rst_n = 1'b1;
    clear_counts();
    step("first");
    check_eq("first_edge_ticks", 64'(tick), 64'hF);
    for (int k = 1; k < 20; k++) step("free");
    check_eq("cnt_div0", 64'(tick_cnt[0]), 64'd20);
    check_eq("cnt_div1", 64'(tick_cnt[1]), 64'd10);
    check_eq("cnt_div4", 64'(tick_cnt[2]), 64'd4);
    check_eq("cnt_div9", 64'(tick_cnt[3]), 64'd2);

    // Restart realigns channel 2: ticks 5, 10 and 15 edges later.
    restart = 4'b0100;
    step("restart");
    restart = '0;
    clear_counts();
    for (int k = 0; k < 4; k++) step("rs_wait");
    check_eq("rs_no_early_tick", 64'(tick_cnt[2]), 64'd0);
    step("rs_first");
    check_eq("rs_tick_at_5", 64'(tick[2]), 64'd1);
    for (int k = 0; k < 10; k++) step("rs_run");
    check_eq("rs_three_ticks", 64'(tick_cnt[2]), 64'd3);

    // Restart with channel disabled: nothing until enable, then full 5-edge period.
    enable[2] = 1'b0;
    restart   = 4'b0100;
    step("rs_dis");
    restart = '0;
    clear_counts();
    for (int k = 0; k < 6; k++) step("rs_dis_hold");
    check_eq("rs_dis_no_tick", 64'(tick_cnt[2]), 64'd0);
    enable[2] = 1'b1;
    for (int k = 0; k < 4; k++) step("rs_dis_run");
    check_eq("rs_dis_wait4", 64'(tick_cnt[2]), 64'd0);
    step("rs_dis_tick");
    check_eq("rs_dis_tick5", 64'(tick[2]), 64'd1);

    // Enable gap of 3 cycles on channel 3 stretches its period by 3.
    restart = 4'b1000;
    step("gap_rs");
    restart = '0;
    clear_counts();
    for (int k = 0; k < 4; k++) step("gap_a");
    enable[3] = 1'b0;
    for (int k = 0; k < 3; k++) step("gap_off");
    enable[3] = 1'b1;
    for (int k = 0; k < 5; k++) step("gap_b");
    check_eq("gap_none_yet", 64'(tick_cnt[3]), 64'd0);
    step("gap_tick");
    check_eq("gap_tick_13", 64'(tick[3]), 64'd1);

    // Maximum divisor then mid-count change: old period of 16 finishes first.
    set_div(0, 15);
    restart = 4'b0001;
    step("max_rs");
    restart = '0;
    clear_counts();
    for (int k = 0; k < 8; k++) step("max_a");
    set_div(0, 2);
    for (int k = 0; k < 7; k++) step("max_b");
    check_eq("max_no_wrap", 64'(tick_cnt[0]), 64'd0);
    step("max_tick");
    check_eq("max_tick_16", 64'(tick[0]), 64'd1);
    for (int k = 0; k < 3; k++) step("max_new");
    check_eq("new_period_3", 64'(tick[0]), 64'd1);

    // Reset mid-count clears everything on the next cycle.
    rst_n = 1'b0;
    step("midrst");
    check_eq("midrst_any", 64'(any_tick), 64'd0);
    rst_n = 1'b1;
    step("post_rst");
    check_eq("post_rst_first", 64'(tick), 64'hF);

`ifdef CLKTICK_ONESHOT_EN
    // One-shot: a single tick 4 edges after restart, busy drops on the same edge.
    set_div(0, 3);
    oneshot = 4'b0001;
    restart = 4'b0001;
    step("os_rs");
    restart = '0;
    clear_counts();
    for (int k = 0; k < 4; k++) step("os_run");
    check_eq("os_tick_at_4", 64'(tick[0]), 64'd1);
    check_eq("os_busy_low", 64'(busy[0]), 64'd0);
    oneshot = '0;
    for (int k = 0; k < 10; k++) step("os_done");
    check_eq("os_single_tick", 64'(tick_cnt[0]), 64'd1);
`endif

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      for (int c = 0; c < N_CH; c++) begin
        enable[c]  = ($urandom_range(0, 7) != 0);
        restart[c] = ($urandom_range(0, 19) == 0);
        case ($urandom_range(0, 15))
          0:       set_div(c, 0);
          1:       set_div(c, (1 << N_BIT) - 1);
          2, 3:    set_div(c, int'($urandom_range(0, (1 << N_BIT) - 1)));
          default: ;
        endcase
`ifdef CLKTICK_ONESHOT_EN
        oneshot[c] = ($urandom_range(0, 3) == 0);
`endif
      end
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
